// File: rtl/elastic_buffer_pkg.sv
// Shared elastic-buffer definitions: line symbols, read-side state encoding,
// pointer-width helper and the registered read-output payload.
package elastic_buffer_pkg;

    localparam int unsigned SYMBOL_WIDTH = 10;

    // Ordered-set symbols, also used by the write-side skip-removal logic
    localparam logic [SYMBOL_WIDTH-1:0] COMMA_SYMBOL = 10'h1BC;
    localparam logic [SYMBOL_WIDTH-1:0] SKIP_SYMBOL  = 10'h1A1;

    // Read-side controller states
    typedef enum logic [1:0] {
        PRIME             = 2'd0,
        WAITING_FOR_COMMA = 2'd1,
        COMMA_DETECTED    = 2'd2,
        SKIP_INSERT       = 2'd3
    } read_state_e;

    // Pointers carry one extra bit so full and empty can be told apart
    function automatic int unsigned ptr_width(input int unsigned address_width);
        return address_width + 1;
    endfunction

    // Registered output word presented to the decoder
    typedef struct packed {
        logic [SYMBOL_WIDTH-1:0] data;
        logic                    valid;
        logic                    skip_added;
        logic                    underflow;
    } read_out_t;

endpackage

// File: rtl/elastic_buffer_read_ctrl_if.sv
// Read-side bus of the elastic buffer: memory read port, pointer exchange
// with the write domain and the symbol stream towards the decoder.
interface elastic_buffer_read_ctrl_if #(
    parameter int unsigned ADDRESS_WIDTH = 4
);
    import elastic_buffer_pkg::*;

    localparam int unsigned PTR_WIDTH = ptr_width(ADDRESS_WIDTH);

    logic [SYMBOL_WIDTH-1:0] buffer_data;
    logic [PTR_WIDTH-1:0]    write_pointer_sync;
    logic [PTR_WIDTH-1:0]    read_pointer_async;
    logic [SYMBOL_WIDTH-1:0] data_out;
    logic                    data_valid;
    logic                    skip_added;
    logic                    underflow;

    // Buffer memory / write domain / decoder side
    modport master (
        output buffer_data,
        output write_pointer_sync,
        input  read_pointer_async,
        input  data_out,
        input  data_valid,
        input  skip_added,
        input  underflow
    );

    // Read controller side
    modport slave (
        input  buffer_data,
        input  write_pointer_sync,
        output read_pointer_async,
        output data_out,
        output data_valid,
        output skip_added,
        output underflow
    );

endinterface

// File: rtl/elastic_buffer_fill_level.sv
// Modular fill level between a write and a read pointer. Shared by the read
// and write sides; the extra pointer bit makes wrap-around need no special case.
module elastic_buffer_fill_level #(
    parameter int unsigned ADDRESS_WIDTH = 4
) (
    input  logic [ADDRESS_WIDTH:0] i_write_pointer,
    input  logic [ADDRESS_WIDTH:0] i_read_pointer,
    output logic [ADDRESS_WIDTH:0] o_fill_level_c
);

    // Subtraction truncated to pointer width is the modulo-2^(ADDRESS_WIDTH+1) difference
    assign o_fill_level_c = i_write_pointer - i_read_pointer;

endmodule

// File: rtl/elastic_buffer_read_ctrl.sv
// Read-side controller of the receive elastic buffer (local clock domain).
// Primes the buffer to START_THRESHOLD after reset, streams one word per
// cycle to the decoder, duplicates one SKIP per comma/SKIP ordered set when
// the fill level is at or below INSERT_THRESHOLD, and flags underflow.
// Optional build macro: ELASTIC_BUFFER_UNDERFLOW_RECOVERY_EN -- when defined,
// an underflow sends the controller back to PRIME so the buffer refills
// before output resumes; when undefined, reading resumes as soon as data
// arrives.
module elastic_buffer_read_ctrl
    import elastic_buffer_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH    = 4,
    parameter int unsigned START_THRESHOLD  = 8,
    parameter int unsigned INSERT_THRESHOLD = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    elastic_buffer_read_ctrl_if.slave   bus
);

    localparam int unsigned PTR_WIDTH = ptr_width(ADDRESS_WIDTH);
    localparam logic [PTR_WIDTH-1:0] START_LEVEL  = PTR_WIDTH'(START_THRESHOLD);
    localparam logic [PTR_WIDTH-1:0] INSERT_LEVEL = PTR_WIDTH'(INSERT_THRESHOLD);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE      = PTR_WIDTH'(1);

    read_state_e           r_state;
    read_state_e           w_state_next;
    logic [PTR_WIDTH-1:0]  r_read_pointer;
    logic [PTR_WIDTH-1:0]  w_read_pointer_next;
    logic [PTR_WIDTH-1:0]  w_fill_level;
    read_out_t             r_out;
    read_out_t             w_out_next;

    logic                  w_running;
    logic                  w_empty;
    logic                  w_is_comma;
    logic                  w_is_skip;
    logic                  w_insert;

    elastic_buffer_fill_level #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_fill_level (
        .i_write_pointer (bus.write_pointer_sync),
        .i_read_pointer  (r_read_pointer),
        .o_fill_level_c  (w_fill_level)
    );

    // Decode of the current read word and buffer occupancy
    assign w_running  = (r_state != PRIME);
    assign w_empty    = (w_fill_level == '0);
    assign w_is_comma = (bus.buffer_data == COMMA_SYMBOL);
    assign w_is_skip  = (bus.buffer_data == SKIP_SYMBOL);
    assign w_insert   = (r_state == COMMA_DETECTED) && w_is_skip
                        && (w_fill_level <= INSERT_LEVEL);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= PRIME;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; an empty buffer while running overrides symbol tracking
    always_comb begin
        w_state_next = r_state;
        if (w_running && w_empty) begin
`ifdef ELASTIC_BUFFER_UNDERFLOW_RECOVERY_EN
            w_state_next = PRIME;
`else
            w_state_next = r_state;
`endif
        end else begin
            case (r_state)
                PRIME: begin
                    if (w_fill_level >= START_LEVEL) begin
                        w_state_next = WAITING_FOR_COMMA;
                    end
                end
                WAITING_FOR_COMMA: begin
                    if (w_is_comma) begin
                        w_state_next = COMMA_DETECTED;
                    end
                end
                COMMA_DETECTED: begin
                    if (w_insert) begin
                        w_state_next = SKIP_INSERT;
                    end else if (w_is_comma) begin
                        w_state_next = COMMA_DETECTED;
                    end else begin
                        w_state_next = WAITING_FOR_COMMA;
                    end
                end
                SKIP_INSERT: begin
                    w_state_next = WAITING_FOR_COMMA;
                end
                default: begin
                    w_state_next = PRIME;
                end
            endcase
        end
    end

    // Output/pointer next values: pulses default low, data_out holds unless a read happens
    always_comb begin
        w_out_next            = r_out;
        w_out_next.valid      = 1'b0;
        w_out_next.skip_added = 1'b0;
        w_out_next.underflow  = 1'b0;
        w_read_pointer_next   = r_read_pointer;
        if (w_running) begin
            if (w_empty) begin
                w_out_next.underflow = 1'b1;
            end else begin
                w_out_next.data       = bus.buffer_data;
                w_out_next.valid      = 1'b1;
                // The flag rides with the duplicate, one cycle after the held SKIP
                w_out_next.skip_added = (r_state == SKIP_INSERT);
                if (!w_insert) begin
                    w_read_pointer_next = r_read_pointer + PTR_ONE;
                end
            end
        end
    end

    // Output and pointer registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_read_pointer <= '0;
            r_out          <= '0;
        end else begin
            r_read_pointer <= w_read_pointer_next;
            r_out          <= w_out_next;
        end
    end

    assign bus.read_pointer_async = r_read_pointer;
    assign bus.data_out           = r_out.data;
    assign bus.data_valid         = r_out.valid;
    assign bus.skip_added         = r_out.skip_added;
    assign bus.underflow          = r_out.underflow;

endmodule

// File: tb/tb_elastic_buffer_read_ctrl.sv
// Scoreboard bench for elastic_buffer_read_ctrl: stimulus pushes expected
// output words, a negedge monitor pops and compares them.
module tb_elastic_buffer_read_ctrl;
    import elastic_buffer_pkg::*;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    elastic_buffer_read_ctrl_if #(.ADDRESS_WIDTH(4)) bus ();

    elastic_buffer_read_ctrl #(
        .ADDRESS_WIDTH    (4),
        .START_THRESHOLD  (8),
        .INSERT_THRESHOLD (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Buffer memory model with combinational read
    logic [9:0] mem [16];
    assign bus.buffer_data = mem[bus.read_pointer_async[3:0]];

    typedef struct {
        bit         uf;
        logic [9:0] data;
        bit         skip;
        logic [4:0] ptr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endfunction

    // Monitor: every valid word or underflow pulse must match the queue head
    always @(negedge clock) begin
        exp_t e;
        if (!reset && (bus.data_valid || bus.underflow)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: valid=%0b underflow=%0b data=%0h ptr=%0d, nothing expected (t=%0t)",
                         bus.data_valid, bus.underflow, bus.data_out, bus.read_pointer_async, $time);
            end else begin
                e = exp_q.pop_front();
                check("underflow",    32'(bus.underflow),          32'(e.uf));
                check("data_valid",   32'(bus.data_valid),         32'(!e.uf));
                check("data_out",     32'(bus.data_out),           32'(e.data));
                check("skip_added",   32'(bus.skip_added),         32'(e.skip));
                check("read_pointer", 32'(bus.read_pointer_async), 32'(e.ptr));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_data(input logic [9:0] d, input bit s, input logic [4:0] p);
        exp_t e;
        e.uf = 1'b0; e.data = d; e.skip = s; e.ptr = p;
        exp_q.push_back(e);
    endtask

    task automatic push_uf(input logic [9:0] d, input logic [4:0] p);
        exp_t e;
        e.uf = 1'b1; e.data = d; e.skip = 1'b0; e.ptr = p;
        exp_q.push_back(e);
    endtask

    // Wait (bounded) until every expected word has been seen
    task automatic drain(input string name);
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clock);
            #1;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_drain: %0d expected words outstanding, 0 required", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset(input string name);
        check({name, "_ptr"},   32'(bus.read_pointer_async), 32'd0);
        check({name, "_data"},  32'(bus.data_out),           32'd0);
        check({name, "_valid"}, 32'(bus.data_valid),         32'd0);
        check({name, "_skip"},  32'(bus.skip_added),         32'd0);
        check({name, "_uf"},    32'(bus.underflow),          32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.write_pointer_sync = 5'd0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Data 50..54, COMMA at 5, SKIP at 6 (fill 3 there with wp=9), then AA, AB
    task automatic load_skip_case();
        for (int a = 0; a < 5; a++) mem[a] = 10'h050 + 10'(a);
        mem[5] = COMMA_SYMBOL;
        mem[6] = SKIP_SYMBOL;
        mem[7] = 10'h0AA;
        mem[8] = 10'h0AB;
    endtask

    task automatic push_skip_stream(input int n);
        exp_t s [12];
        for (int a = 0; a < 5; a++) begin
            s[a].uf = 1'b0; s[a].data = 10'h050 + 10'(a); s[a].skip = 1'b0; s[a].ptr = 5'(a + 1);
        end
        s[5]  = '{1'b0, COMMA_SYMBOL, 1'b0, 5'd6};
        s[6]  = '{1'b0, SKIP_SYMBOL,  1'b0, 5'd6};
        s[7]  = '{1'b0, SKIP_SYMBOL,  1'b1, 5'd7};
        s[8]  = '{1'b0, 10'h0AA,      1'b0, 5'd8};
        s[9]  = '{1'b0, 10'h0AB,      1'b0, 5'd9};
        s[10] = '{1'b1, 10'h0AB,      1'b0, 5'd9};
        s[11] = s[10];
        for (int i = 0; i < n && i < 11; i++) exp_q.push_back(s[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 10'h040 + 10'(i);
        bus.write_pointer_sync = 5'd0;
        reset = 1'b1;
        #3;
        check_reset("reset");
        tick();
        tick();
        reset = 1'b0;

        // Priming, exit timing and underflow
        repeat (3) tick();
        check("prime_ptr",   32'(bus.read_pointer_async), 32'd0);
        check("prime_valid", 32'(bus.data_valid),         32'd0);
        for (int a = 0; a < 8; a++) push_data(10'h040 + 10'(a), 1'b0, 5'(a + 1));
        push_uf(10'h047, 5'd8);
        bus.write_pointer_sync = 5'd8;
        tick();
        check("exit_edge_ptr",   32'(bus.read_pointer_async), 32'd0);
        check("exit_edge_valid", 32'(bus.data_valid),         32'd0);
        tick();
        check("first_read_ptr",   32'(bus.read_pointer_async), 32'd1);
        check("first_read_valid", 32'(bus.data_valid),         32'd1);
        repeat (8) tick();
        check("underflow_pulse", 32'(bus.underflow), 32'd1);
        for (int a = 8; a < 16; a++) push_data(10'h040 + 10'(a), 1'b0, 5'(a + 1));
        push_uf(10'h04F, 5'd16);
        bus.write_pointer_sync = 5'd16;
        tick();
`ifdef ELASTIC_BUFFER_UNDERFLOW_RECOVERY_EN
        check("reprime_after_underflow_valid", 32'(bus.data_valid), 32'd0);
`else
        check("resume_after_underflow_valid",  32'(bus.data_valid), 32'd1);
`endif
        drain("priming");
        do_reset();

        // SKIP insertion at fill 3
        load_skip_case();
        push_skip_stream(11);
        bus.write_pointer_sync = 5'd9;
        drain("skip_insert");
        do_reset();

        // COMMA, SKIP at fill 6: no insertion
        mem[0] = 10'h060;
        mem[1] = COMMA_SYMBOL;
        mem[2] = SKIP_SYMBOL;
        for (int a = 3; a < 8; a++) mem[a] = 10'h061 + 10'(a - 3);
        push_data(10'h060, 1'b0, 5'd1);
        push_data(COMMA_SYMBOL, 1'b0, 5'd2);
        push_data(SKIP_SYMBOL, 1'b0, 5'd3);
        for (int a = 3; a < 8; a++) push_data(10'h061 + 10'(a - 3), 1'b0, 5'(a + 1));
        push_uf(10'h065, 5'd8);
        bus.write_pointer_sync = 5'd8;
        drain("no_insert");
        do_reset();

        // Pointer wrap: writer streams until wp=35 (mod 32 = 3), reader drains through 31->0
        for (int k = 0; k < 8; k++) begin
            mem[k] = 10'h100 + 10'(k);
            push_data(10'h100 + 10'(k), 1'b0, 5'(k + 1));
        end
        bus.write_pointer_sync = 5'd8;
        for (int k = 8; k < 35; k++) begin
            tick();
            mem[k % 16] = 10'h100 + 10'(k);
            push_data(10'h100 + 10'(k), 1'b0, 5'(k + 1));
            bus.write_pointer_sync = 5'(k + 1);
        end
        push_uf(10'h122, 5'd3);
        drain("wrap");
        do_reset();

        // Reset while in SKIP_INSERT, then re-prime
        load_skip_case();
        push_skip_stream(7);
        bus.write_pointer_sync = 5'd9;
        drain("pre_reset_skip");
        reset = 1'b1;
        #1;
        check_reset("reset_in_skip_insert");
        tick();
        reset = 1'b0;
        push_skip_stream(11);
        drain("reprime_after_reset");
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
